// File: rtl/pc_unit_pkg.sv
// Shared fetch-stage constants: PC width, reset/interrupt vector addresses and
// the encoding of the pc_unit state machine.
package pc_unit_pkg;

  localparam int unsigned PC_WIDTH     = 16;
  localparam logic [15:0] PC_RESET_VEC = 16'h0000;
  localparam logic [15:0] PC_INT_VEC   = 16'h0001;

  typedef enum logic [1:0] {
    VEC_RST = 2'd0,
    RUN     = 2'd1,
    VEC_INT = 2'd2,
    HALTED  = 2'd3
  } pc_state_e;

endpackage

// File: rtl/pc_unit_mux.sv
// Next-PC select: y = sel ? i1 : i0. Purely combinational, no state.
module mux_2x1_16bit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] i0_i,
  input  logic [WIDTH-1:0] i1_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = sel_i ? i1_i : i0_i;

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: reset/interrupt vector loads, branch, stall, halt, EPC save.
// pc/epc/int_ack update one edge after their cause; imem_addr and valid decode from state and pc only.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int unsigned      WIDTH     = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC),
  parameter logic [WIDTH-1:0] INT_VEC   = WIDTH'(PC_INT_VEC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             int_req,
  input  logic             halt,
  input  logic [WIDTH-1:0] imem_data,
  output logic [WIDTH-1:0] imem_addr,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_one,
  output logic [WIDTH-1:0] epc,
  output logic             int_ack,
  output logic             valid
);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             int_ack_q, int_ack_d;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc_sel;

  assign pc_inc = pc_q + WIDTH'(1);

  mux_2x1_16bit #(
    .WIDTH (WIDTH)
  ) u_next_pc_mux (
    .i0_i  (pc_inc),
    .i1_i  (branch_target),
    .sel_i (branch_taken),
    .y_o   (pc_sel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= VEC_RST;
      pc_q      <= '0;
      epc_q     <= '0;
      int_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      int_ack_q <= int_ack_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    epc_d     = epc_q;
    int_ack_d = 1'b0;
    unique case (state_q)
      VEC_RST: begin
        pc_d    = imem_data;
        state_d = RUN;
      end
      RUN: begin
        // Branch outranks stall so a pipeline flush is never dropped.
        if (halt) begin
          state_d = HALTED;
        end else if (branch_taken) begin
          pc_d = pc_sel;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (int_req) begin
          epc_d   = pc_inc;
          state_d = VEC_INT;
        end else begin
          pc_d = pc_sel;
        end
      end
      VEC_INT: begin
        pc_d      = imem_data;
        int_ack_d = 1'b1;
        state_d   = RUN;
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: state_d = VEC_RST;
    endcase
  end

  always_comb begin
    imem_addr = pc_q;
    unique case (state_q)
      VEC_RST: imem_addr = RESET_VEC;
      VEC_INT: imem_addr = INT_VEC;
      default: imem_addr = pc_q;
    endcase
  end

  assign valid       = (state_q == RUN);
  assign pc          = pc_q;
  assign pc_plus_one = pc_inc;
  assign epc         = epc_q;
  assign int_ack     = int_ack_q;

endmodule
